// File: rtl/bit_patlatma_hakem.sv
`default_nettype none
// ============================================================================
// Module   : bit_patlatma_hakem
// Desc     : Round-robin sequencer that shifts one of two requesters' words
//            MSB-first onto the bit-popping datapath and freezes on its done
//            flag. Optional per-requester word counters: BIT_PATLATMA_SAYAC_EN.
// Revision : 1.0 - initial release
// ============================================================================
module bit_patlatma_hakem #(
    parameter int W   = 8,
    parameter int ARA = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0,
    input  logic [W-1:0] veri0,
    output logic         ack0,
    input  logic         req1,
    input  logic [W-1:0] veri1,
    output logic         ack1,
    output logic         bit_o,
    output logic         bit_gecerli,
    input  logic         bitti_mi,
    input  logic         yeniden,
    output logic         mesgul,
    output logic         izin,
    output logic         bitti,
    output logic         kazanan
`ifdef BIT_PATLATMA_SAYAC_EN
    ,
    output logic [7:0]   sayac0,
    output logic [7:0]   sayac1
`endif
);

    localparam int c_CW = (W > 1) ? $clog2(W) : 1;
    localparam int c_GW = (ARA > 1) ? $clog2(ARA) : 1;

    localparam logic [c_CW-1:0] c_LAST     = c_CW'(W - 1);
    localparam logic [c_CW-1:0] c_BIT_ONE  = c_CW'(1);
    localparam logic [c_GW-1:0] c_GAP_LOAD = c_GW'((ARA > 0) ? (ARA - 1) : 0);
    localparam logic [c_GW-1:0] c_GAP_ONE  = c_GW'(1);

    typedef enum logic [1:0] {
        S_BOSTA  = 2'd0,
        S_GONDER = 2'd1,
        S_ARA    = 2'd2,
        S_BITTI  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [W-1:0]    r_word;
    logic [c_CW-1:0] r_bit_cnt;
    logic [c_GW-1:0] r_gap_cnt;
    logic            r_izin;
    logic            r_prio;
    logic            r_kazanan;
    logic            r_ack0;
    logic            r_ack1;

    logic            w_grant;
    logic            w_grant_id;
    logic            w_done;
    logic            w_last_bit;

    assign w_last_bit = (r_bit_cnt == '0);

    always_comb begin
        w_next_state = r_state;
        w_grant      = 1'b0;
        w_grant_id   = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_BOSTA: begin
                if (bitti_mi) begin
                    w_next_state = S_BITTI;
                    w_done       = 1'b1;
                end else if (req0 || req1) begin
                    // r_prio names the requester that was not granted last
                    w_grant      = 1'b1;
                    w_grant_id   = (req0 && req1) ? r_prio : req1;
                    w_next_state = S_GONDER;
                end
            end
            S_GONDER: begin
                if (bitti_mi) begin
                    w_next_state = S_BITTI;
                    w_done       = 1'b1;
                end else if (w_last_bit) begin
                    w_next_state = (ARA == 0) ? S_BOSTA : S_ARA;
                end
            end
            S_ARA: begin
                if (bitti_mi) begin
                    w_next_state = S_BITTI;
                    w_done       = 1'b1;
                end else if (r_gap_cnt == '0) begin
                    w_next_state = S_BOSTA;
                end
            end
            S_BITTI: begin
                if (yeniden) begin
                    w_next_state = S_BOSTA;
                end
            end
            default: w_next_state = S_BOSTA;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_BOSTA;
            r_word    <= '0;
            r_bit_cnt <= '0;
            r_gap_cnt <= '0;
            r_izin    <= 1'b0;
            r_prio    <= 1'b0;
            r_kazanan <= 1'b0;
            r_ack0    <= 1'b0;
            r_ack1    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;

            if (w_grant) begin
                r_word    <= w_grant_id ? veri1 : veri0;
                r_izin    <= w_grant_id;
                r_prio    <= ~w_grant_id;
                r_ack0    <= ~w_grant_id;
                r_ack1    <= w_grant_id;
                r_bit_cnt <= c_LAST;
            end else if (r_state == S_GONDER) begin
                r_bit_cnt <= r_bit_cnt - c_BIT_ONE;
            end

            if (r_state == S_GONDER && w_next_state == S_ARA) begin
                r_gap_cnt <= c_GAP_LOAD;
            end else if (r_state == S_ARA) begin
                r_gap_cnt <= r_gap_cnt - c_GAP_ONE;
            end

            if (w_done) begin
                r_kazanan <= r_izin;
            end else if (r_state == S_BITTI && yeniden) begin
                r_kazanan <= 1'b0;
            end
        end
    end

    assign bit_gecerli = (r_state == S_GONDER);
    assign bit_o       = bit_gecerli & r_word[r_bit_cnt];
    assign mesgul      = (r_state == S_GONDER) || (r_state == S_ARA);
    assign bitti       = (r_state == S_BITTI);
    assign izin        = r_izin;
    assign kazanan     = r_kazanan;
    assign ack0        = r_ack0;
    assign ack1        = r_ack1;

`ifdef BIT_PATLATMA_SAYAC_EN
    logic [7:0] r_sayac0;
    logic [7:0] r_sayac1;

    // A done flag seen on the last bit still leaves the whole word delivered
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sayac0 <= 8'd0;
            r_sayac1 <= 8'd0;
        end else if (r_state == S_GONDER && w_last_bit) begin
            if (!r_izin && r_sayac0 != 8'hFF) begin
                r_sayac0 <= r_sayac0 + 8'd1;
            end
            if (r_izin && r_sayac1 != 8'hFF) begin
                r_sayac1 <= r_sayac1 + 8'd1;
            end
        end
    end

    assign sayac0 = r_sayac0;
    assign sayac1 = r_sayac1;
`endif

endmodule
`default_nettype wire
